// File: rtl/restart_stop_ctl.sv
// Restart/stop sequencer for the timer: holds GOJAM for whole MCTs after any restart source,
// handles monitor stop and single-MCT stepping, and keeps a sticky restart-cause register.
`timescale 1ns/1ps

module restart_stop_ctl #(
  parameter int GOJAM_MCT   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       SIM_RST,
  input  logic       T12_STB,
  input  logic       STRT1,
  input  logic       STRT2,
  input  logic       SBY,
  input  logic       ALGA,
  input  logic       GOJ1,
  input  logic       MSTP,
  input  logic       MSTRTP,
  input  logic       CAUSE_RD,
  output logic       GOJAM,
  output logic       GOJAM_n,
  output logic       STOP,
  output logic       STOP_n,
  output logic [4:0] CAUSE,
  output logic       RSTRT_LGT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    GOJ_WAIT = 3'd1,
    GOJ      = 3'd2,
    STOPPED  = 3'd3,
    STEP     = 3'd4
  } state_t;

  localparam logic [3:0] MCT_LOAD = 4'(GOJAM_MCT);

  logic [6:0]                  async_in;
  logic [SYNC_STAGES-1:0][6:0] sync_pipe;
  logic [6:0]                  sync_out;
  logic [4:0]                  src_sync;
  logic [4:0]                  src_prev;
  logic [4:0]                  src_rise;
  logic                        mstp_sync;
  logic                        mstrtp_sync;
  logic                        mstrtp_prev;
  logic                        step_req;
  logic                        req;

  logic [4:0] cause_q;
  state_t     state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic       gojam_q, gojam_d;
  logic       stop_q, stop_d;

  assign async_in = {MSTRTP, MSTP, GOJ1, ALGA, SBY, STRT2, STRT1};

  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out    = sync_pipe[SYNC_STAGES-1];
  assign src_sync    = sync_out[4:0];
  assign mstp_sync   = sync_out[5];
  assign mstrtp_sync = sync_out[6];
  assign req         = |src_sync;

  // MSTRTP history resets high so a step button held through reset is not taken as an edge.
  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      src_prev    <= '0;
      mstrtp_prev <= 1'b1;
    end else begin
      src_prev    <= src_sync;
      mstrtp_prev <= mstrtp_sync;
    end
  end

  assign src_rise = src_sync & ~src_prev;
  assign step_req = mstrtp_sync & ~mstrtp_prev;

  // A fresh source edge survives a simultaneous read so no restart cause is ever lost.
  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      cause_q <= '0;
    end else begin
      cause_q <= (CAUSE_RD ? 5'b0 : cause_q) | src_rise;
    end
  end

  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q <= GOJ;
      mcnt_q  <= MCT_LOAD;
      gojam_q <= 1'b1;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      gojam_q <= gojam_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    gojam_d = gojam_q;
    stop_d  = stop_q;

    if (state_q == GOJ) begin
      if (T12_STB) begin
        if (req) begin
          mcnt_d = MCT_LOAD;
        end else if (mcnt_q == 4'd1) begin
          state_d = RUN;
          gojam_d = 1'b0;
        end else begin
          mcnt_d = mcnt_q - 4'd1;
        end
      end
    end else if (state_q == GOJ_WAIT) begin
      // Already committed to a restart: only the MCT boundary moves us on.
      if (T12_STB) begin
        state_d = GOJ;
        gojam_d = 1'b1;
        mcnt_d  = MCT_LOAD;
      end
    end else if (req) begin
      state_d = GOJ_WAIT;
      stop_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (T12_STB && mstp_sync) begin
            state_d = STOPPED;
            stop_d  = 1'b1;
          end
        end
        STOPPED: begin
          if (!mstp_sync) begin
            state_d = RUN;
            stop_d  = 1'b0;
          end else if (step_req) begin
            state_d = STEP;
            stop_d  = 1'b0;
          end
        end
        STEP: begin
          if (T12_STB) begin
            state_d = mstp_sync ? STOPPED : RUN;
            stop_d  = mstp_sync;
          end
        end
        default: begin
          state_d = RUN;
          stop_d  = 1'b0;
        end
      endcase
    end
  end

  assign GOJAM     = gojam_q;
  assign GOJAM_n   = ~gojam_q;
  assign STOP      = stop_q;
  assign STOP_n    = ~stop_q;
  assign CAUSE     = cause_q;
  assign RSTRT_LGT = |cause_q;
  assign STATE     = state_q;

endmodule
